seq_scan_ctrl: RTL and testbench

Controller that takes a parallel data word through a start handshake, serializes it MSB-first into a pattern-matching core, and counts occurrences of a fixed bit pattern. Overlapping occurrences are counted. It reports the match count and a 2-bit status code. It sits in front of the sequence-detection datapath and schedules one scan per accepted word.

---
 rtl/seq_pkg.sv | 17 +
 rtl/seq_match_core.sv | 48 ++++
 rtl/seq_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the sequence scan controller.
//   state_t      - controller FSM states (IDLE, SHIFT, DONE)
//   RES_*        - 2-bit status codes driven on seq_scan_ctrl.result
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] RES_IDLE    = 2'b00;
    localparam logic [1:0] RES_BUSY    = 2'b01;
    localparam logic [1:0] RES_NOMATCH = 2'b10;
    localparam logic [1:0] RES_MATCH   = 2'b11;

endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: serial pattern matcher with a PAT_W-bit history.
// Ports:
//   clk       in  clock, rising edge
//   rst       in  synchronous active-high reset
//   clear     in  synchronous clear of history and fill counter (new word)
//   bit_in    in  current serial bit (earliest bit first)
//   bit_valid in  bit_in is consumed this cycle
//   match     out combinational: history plus bit_in equals PATTERN and
//                 at least PAT_W bits have been consumed since the clear
module seq_match_core #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_in,
    input  logic bit_valid,
    output logic match
);

    localparam int FW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    // Fill saturates once PAT_W-1 earlier bits have been seen; the current
    // bit then completes a full window.
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] window;
    logic [FW-1:0]    fill_q;

    // Newest bit enters at the LSB, so the oldest bit lines up with
    // PATTERN's MSB.
    assign window = PAT_W'({hist_q, bit_in});
    assign match  = bit_valid && (window == PATTERN) && (fill_q == FILL_MAX);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (bit_valid) begin
            hist_q <= window;
            if (fill_q != FILL_MAX) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts a word on start, serializes it MSB-first into
// seq_match_core and counts (overlapping) occurrences of PATTERN.
// Ports:
//   clockPulse  in  clock, rising edge
//   reset       in  synchronous active-high reset, priority over all inputs
//   start       in  scan request, accepted only in IDLE
//   data_in     in  word captured on the accepting edge
//   busy        out high during SHIFT cycles (registered)
//   done        out one-cycle pulse in DONE (registered)
//   match_count out match count of last completed scan
//   result      out status code (seq_pkg RES_*)
//   bit_out     out serial bit presented to the core
//   bit_valid   out same as busy
//   dbg_state   out current FSM state for observation
//
// Handshake: start is a level request; the controller accepts it on any
// rising edge where it is in IDLE and ignores it otherwise. There is no
// back-pressure and no queuing; acceptance is visible as busy rising.
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter int               DATA_W  = 16,
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 5
) (
    input  logic              clockPulse,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_count,
    output logic [1:0]        result,
    output logic              bit_out,
    output logic              bit_valid,
    output state_t            dbg_state
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  mc_q, mc_d;
    logic [1:0]        res_q, res_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              core_clear;
    logic              core_match;
    logic              cur_bit;

    assign cur_bit = shreg_q[DATA_W-1];

    seq_match_core #(
        .PAT_W  (PAT_W),
        .PATTERN(PATTERN)
    ) u_core (
        .clk      (clockPulse),
        .rst      (reset),
        .clear    (core_clear),
        .bit_in   (cur_bit),
        .bit_valid(busy_q),
        .match    (core_match)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        run_d      = run_q;
        mc_d       = mc_q;
        res_d      = res_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        core_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SHIFT;
                    shreg_d    = data_in;
                    bit_cnt_d  = '0;
                    run_d      = '0;
                    res_d      = RES_BUSY;
                    core_clear = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            SHIFT: begin
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (core_match && (run_q != '1)) begin
                    run_d = run_q + 1'b1;
                end
                if (bit_cnt_q == LAST_BIT) begin
                    // Publish on the edge into DONE so the count, including a
                    // match on the final bit, is visible in the DONE cycle.
                    state_d = DONE;
                    mc_d    = run_d;
                    res_d   = (run_d != '0) ? RES_MATCH : RES_NOMATCH;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clockPulse) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            run_q     <= '0;
            mc_q      <= '0;
            res_q     <= RES_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            run_q     <= run_d;
            mc_q      <= mc_d;
            res_q     <= res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy        = busy_q;
    assign bit_valid   = busy_q;
    assign done        = done_q;
    assign match_count = mc_q;
    assign result      = res_q;
    assign bit_out     = busy_q & cur_bit;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
module tb_seq_scan_ctrl;
    import seq_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [15:0] data_in;
    logic        busy, done, bit_out, bit_valid;
    logic [4:0]  match_count;
    logic [1:0]  result;
    state_t      dbg_state;

    logic        start8;
    logic [7:0]  data8;
    logic        busy8, done8, bit_out8, bit_valid8;
    logic [2:0]  mc8;
    logic [1:0]  res8;
    state_t      st8;

    seq_scan_ctrl dut (
        .clockPulse (clk),
        .reset      (reset),
        .start      (start),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .match_count(match_count),
        .result     (result),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .dbg_state  (dbg_state)
    );

    seq_scan_ctrl #(
        .DATA_W (8),
        .PAT_W  (1),
        .PATTERN(1'b1),
        .CNT_W  (3)
    ) dut8 (
        .clockPulse (clk),
        .reset      (reset),
        .start      (start8),
        .data_in    (data8),
        .busy       (busy8),
        .done       (done8),
        .match_count(mc8),
        .result     (res8),
        .bit_out    (bit_out8),
        .bit_valid  (bit_valid8),
        .dbg_state  (st8)
    );

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: slide a 4-bit window over the word, oldest bit first,
    // count windows equal to 1011, saturate at the counter limit.
    function automatic int model_count(input logic [15:0] d);
        int c = 0;
        for (int i = 0; i <= 12; i++) begin
            if (((d >> (12 - i)) & 16'hF) == 16'hB) c++;
        end
        return (c > 31) ? 31 : c;
    endfunction

    function automatic logic [1:0] model_res(input int cnt);
        return (cnt != 0) ? 2'b11 : 2'b10;
    endfunction

    // ---------------- driver: one complete scan, DUT in IDLE on entry ----------------
    task automatic run_scan(input logic [15:0] d, input int exp_cnt, input string tag);
        logic [15:0] ser;
        logic [4:0]  mc_before;
        int          busy_cyc, done_seen;
        logic        res_ok, mc_held;
        mc_before = match_count;
        start     = 1'b1;
        data_in   = d;
        tick();                       // edge 0 accepted, now cycle 1
        start     = 1'b0;
        data_in   = 16'($urandom);    // must not disturb the captured word
        ser       = '0;
        busy_cyc  = 0;
        done_seen = 0;
        res_ok    = 1'b1;
        mc_held   = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            ser = {ser[14:0], bit_out};
            if (busy && bit_valid) busy_cyc++;
            if (done) done_seen++;
            if (result !== RES_BUSY) res_ok = 1'b0;
            if (match_count !== mc_before) mc_held = 1'b0;
            if (k == 3) start = 1'b1;   // ignored while busy
            if (k == 4) start = 1'b0;
            tick();
        end
        // cycle 17: DONE
        check({tag, "_serial"},    ser, d);
        check({tag, "_busy_cyc"},  busy_cyc, 16);
        check({tag, "_done_early"}, done_seen, 0);
        check({tag, "_res_busy"},  res_ok, 1);
        check({tag, "_mc_held"},   mc_held, 1);
        check({tag, "_done"},      {busy, bit_valid, done}, 3'b001);
        check({tag, "_count"},     match_count, exp_cnt);
        check({tag, "_result"},    result, model_res(exp_cnt));
        tick();
        // cycle 18: back in IDLE, results held
        check({tag, "_idle"},      {busy, done, dbg_state}, {1'b0, 1'b0, IDLE});
        check({tag, "_hold"},      {match_count, result}, {5'(exp_cnt), model_res(exp_cnt)});
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- stimulus tables ----------------
    typedef struct {
        logic [15:0] data;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic        ok;
        logic        idle_ok;
        int          rise, dn, done_c;
        logic        prev_busy;
        logic [2:0]  mc8_at_done;
        logic [1:0]  res8_at_done;
        logic [15:0] rd;

        tbl[0] = '{16'h0000, 0};
        tbl[1] = '{16'hB6DB, 5};
        tbl[2] = '{16'hBBBB, 4};
        tbl[3] = '{16'h000B, 1};
        tbl[4] = '{16'hFFFF, 0};
        tbl[5] = '{16'hB000, 1};

        reset   = 1'b1;
        start   = 1'b0;
        data_in = '0;
        start8  = 1'b0;
        data8   = '0;
        tick();
        tick();
        reset = 1'b0;

        // reset values held through 5 idle cycles
        idle_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if ({busy, done, bit_out, bit_valid, match_count, result} !== '0 || dbg_state !== IDLE)
                idle_ok = 1'b0;
            tick();
        end
        check("reset_idle", idle_ok, 1);

        // table-driven scans
        foreach (tbl[i]) run_scan(tbl[i].data, tbl[i].exp_cnt, $sformatf("tbl%0d", i));

        // randomized scans against the reference model
        for (int i = 0; i < 24; i++) begin
            rd = (i % 3 == 0) ? 16'($urandom_range(0, 65535)) | 16'hB0B0 : 16'($urandom_range(0, 65535));
            run_scan(rd, model_count(rd), $sformatf("rnd%0d", i));
        end

        // start held high: second acceptance only at edge 18
        start   = 1'b1;
        data_in = 16'hBBBB;
        tick();                       // cycle 1
        rise      = -1;
        dn        = 0;
        prev_busy = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 18) check("held_c18", {match_count, result, busy}, {5'd4, RES_MATCH, 1'b0});
            if (c == 19) check("held_c19_res", result, RES_BUSY);
            if (c > 1 && busy && !prev_busy && rise < 0) rise = c;
            if (done && c <= 18) dn++;
            prev_busy = busy;
            tick();
        end
        start = 1'b0;
        check("held_rise_cycle", rise, 19);
        check("held_done_once", dn, 1);
        wait_done(30, ok);
        check("held_second_done", ok, 1);
        check("held_second_cnt", match_count, 4);
        tick();

        // reset in the 6th SHIFT cycle aborts the scan
        start   = 1'b1;
        data_in = 16'hB6DB;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();   // now in cycle 6
        reset = 1'b1;
        tick();                               // cycle 7
        check("rst_mid_outs", {busy, done, bit_valid, bit_out, match_count, result}, 11'd0);
        check("rst_mid_state", dbg_state, IDLE);
        reset = 1'b0;
        tick();
        check("rst_after_busy", busy, 0);
        run_scan(16'hBBBB, 4, "post_rst");

        // saturation in the 8-bit, single-bit-pattern configuration
        start8 = 1'b1;
        data8  = 8'hFF;
        tick();
        start8       = 1'b0;
        done_c       = -1;
        mc8_at_done  = '0;
        res8_at_done = '0;
        for (int c = 1; c <= 12; c++) begin
            if (done8 && done_c < 0) begin
                done_c       = c;
                mc8_at_done  = mc8;
                res8_at_done = res8;
            end
            tick();
        end
        check("sat_done_cycle", done_c, 9);
        check("sat_count", mc8_at_done, 7);
        check("sat_result", res8_at_done, RES_MATCH);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
